// File: rtl/adat_frame_deframer_if.sv
// Bit-stream input and deframed-sample output bundle for adat_frame_deframer.
// The master drives the decoded ADAT bit stream. The slave is the deframer and returns samples and status.
interface adat_frame_deframer_if;
    logic        data_i;
    logic        valid_i;
    logic        sync_i;
    logic [23:0] sample_o;
    logic [2:0]  channel_o;
    logic        sample_valid_o;
    logic [3:0]  user_o;
    logic        frame_o;
    logic        locked_o;
    logic [7:0]  err_count_o;

    modport master (
        output data_i, valid_i, sync_i,
        input  sample_o, channel_o, sample_valid_o, user_o, frame_o, locked_o, err_count_o
    );

    modport slave (
        input  data_i, valid_i, sync_i,
        output sample_o, channel_o, sample_valid_o, user_o, frame_o, locked_o, err_count_o
    );
endinterface

// File: rtl/adat_frame_deframer.sv
// ADAT frame deframer. It aligns to the sync run, checks the framing bits and splits each 256-bit frame
// into eight 24-bit samples plus four user bits.
module adat_frame_deframer #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    adat_frame_deframer_if.slave  bus
);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic {HUNT, FRAME} state_t;

    state_t      state_reg;
    logic [3:0]  zero_run_reg;
    logic [7:0]  pos_reg;
    logic [23:0] shift_reg;
    logic [3:0]  user_acc_reg;
    logic [3:0]  good_cnt_reg;
    logic [23:0] sample_reg;
    logic [2:0]  channel_reg;
    logic        sample_valid_reg;
    logic [3:0]  user_reg;
    logic        frame_reg;
    logic        locked_reg;
    logic [7:0]  err_count_reg;

    logic [47:0] sep_hit;
    logic [7:0]  done_hit;
    logic        is_sep;
    logic        is_data;
    logic        is_user;
    logic        is_sync_zone;
    logic        frame_err;
    logic        chan_done;
    logic [2:0]  chan_idx;
    logic [23:0] shift_next;
    logic [3:0]  good_cnt_next;

    // Positions are decoded with one equality compare for each nibble separator and each channel end.
    genvar gi;
    generate
        for (gi = 0; gi < 48; gi++) begin : g_sep
            assign sep_hit[gi] = (pos_reg == 8'(10 + 5 * gi));
        end
        for (gi = 0; gi < 8; gi++) begin : g_done
            assign done_hit[gi] = (pos_reg == 8'(34 + 30 * gi));
        end
    endgenerate

    always_comb begin
        chan_done = 1'b0;
        chan_idx  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (done_hit[i]) begin
                chan_done = 1'b1;
                chan_idx  = 3'(i);
            end
        end
    end

    assign is_sep       = (pos_reg == 8'd0) || (pos_reg == 8'd5) || (|sep_hit);
    assign is_user      = (pos_reg >= 8'd1) && (pos_reg <= 8'd4);
    assign is_data      = (pos_reg >= 8'd6) && (pos_reg <= 8'd245) && !is_sep;
    assign is_sync_zone = (pos_reg >= 8'd246);
    assign shift_next   = {shift_reg[22:0], bus.data_i};
    assign good_cnt_next = (good_cnt_reg >= LOCK_N) ? LOCK_N : good_cnt_reg + 4'd1;

    assign frame_err = (state_reg == FRAME) &&
                       (!bus.valid_i ||
                        (is_sep && !bus.data_i) ||
                        (is_sync_zone && bus.data_i) ||
                        (bus.sync_i && (pos_reg < 8'd253)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg        <= HUNT;
            zero_run_reg     <= 4'd0;
            pos_reg          <= 8'd0;
            shift_reg        <= 24'd0;
            user_acc_reg     <= 4'd0;
            good_cnt_reg     <= 4'd0;
            sample_reg       <= 24'd0;
            channel_reg      <= 3'd0;
            sample_valid_reg <= 1'b0;
            user_reg         <= 4'd0;
            frame_reg        <= 1'b0;
            locked_reg       <= 1'b0;
            err_count_reg    <= 8'd0;
        end else begin
            sample_valid_reg <= 1'b0;
            frame_reg        <= 1'b0;

            // The zero run is updated on every cycle, including the bit that causes an error.
            if (bus.valid_i && !bus.data_i)
                zero_run_reg <= (zero_run_reg == 4'd15) ? 4'd15 : zero_run_reg + 4'd1;
            else
                zero_run_reg <= 4'd0;

            case (state_reg)
                HUNT: begin
                    if (bus.valid_i && bus.data_i && (zero_run_reg >= 4'd10)) begin
                        state_reg <= FRAME;
                        pos_reg   <= 8'd1;
                    end
                end
                FRAME: begin
                    if (frame_err) begin
                        state_reg     <= HUNT;
                        err_count_reg <= (err_count_reg == 8'd255) ? 8'd255 : err_count_reg + 8'd1;
                        good_cnt_reg  <= 4'd0;
                        locked_reg    <= 1'b0;
                        shift_reg     <= 24'd0;
                    end else begin
                        pos_reg <= pos_reg + 8'd1;
                        if (is_user)
                            user_acc_reg <= {user_acc_reg[2:0], bus.data_i};
                        if (is_data)
                            shift_reg <= shift_next;
                        if (chan_done && locked_reg) begin
                            sample_reg       <= shift_next;
                            channel_reg      <= chan_idx;
                            sample_valid_reg <= 1'b1;
                        end
                        if (pos_reg == 8'd255) begin
                            user_reg     <= user_acc_reg;
                            frame_reg    <= locked_reg;
                            good_cnt_reg <= good_cnt_next;
                            if (good_cnt_next == LOCK_N)
                                locked_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= HUNT;
            endcase
        end
    end

    assign bus.sample_o       = sample_reg;
    assign bus.channel_o      = channel_reg;
    assign bus.sample_valid_o = sample_valid_reg;
    assign bus.user_o         = user_reg;
    assign bus.frame_o        = frame_reg;
    assign bus.locked_o       = locked_reg;
    assign bus.err_count_o    = err_count_reg;
endmodule

// File: tb/tb_adat_frame_deframer.sv
// Directed bench for adat_frame_deframer. It sends clean and corrupted ADAT frames and checks strobes,
// lock and error counting against values built independently of the DUT.
module tb_adat_frame_deframer;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tb_run   = 0;
    int   exp_err  = 0;

    adat_frame_deframer_if bus();

    adat_frame_deframer #(.LOCK_FRAMES(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present one input cycle. On return the outputs show that cycle's effect.
    task automatic drive(input logic b, input logic v, input logic s);
        @(negedge clk_i);
        bus.data_i  = b;
        bus.valid_i = v;
        bus.sync_i  = s;
        @(posedge clk_i);
        #1;
    endtask

    // Accepted bit. sync_i follows the decoder's own zero-run flag unless it is forced high.
    task automatic send_bit(input logic b, input logic force_sync);
        if (b) tb_run = 0;
        else if (tb_run < 15) tb_run++;
        drive(b, 1'b1, force_sync || (tb_run >= 8));
    endtask

    task automatic gap();
        tb_run = 0;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [255:0] build_frame(input logic [3:0] user, input logic [23:0] base);
        logic [255:0] f;
        logic [23:0]  val;
        logic [3:0]   nib;
        f = '0;
        f[0] = 1'b1;
        for (int i = 0; i < 4; i++) f[1 + i] = user[3 - i];
        f[5] = 1'b1;
        for (int k = 0; k < 48; k++) begin
            val = base + 24'(k / 6);
            nib = 4'((val >> (20 - 4 * (k % 6))) & 24'hF);
            for (int j = 0; j < 4; j++) f[6 + 5 * k + j] = nib[3 - j];
            f[10 + 5 * k] = 1'b1;
        end
        return f;
    endfunction

    // err_kind: 0 clean, 1 forced-zero separator, 2 spurious sync, 3 three-cycle valid dropout.
    task automatic send_frame(input logic [3:0] user, input logic [23:0] base, input logic live_in,
                              input int err_kind, input int err_pos);
        logic [255:0] f;
        logic         live;
        logic         b;
        logic         exp_sv;
        int           c;
        f    = build_frame(user, base);
        live = live_in;
        for (int p = 0; p < 256; p++) begin
            b = f[p];
            if (err_kind == 3 && p == err_pos) begin
                gap(); gap(); gap();
                exp_err++;
                live = 1'b0;
                chk("dropout_locked", bus.locked_o, 0);
                chk("dropout_errcnt", bus.err_count_o, exp_err);
                send_bit(b, 1'b0);
            end else if (err_kind == 1 && p == err_pos) begin
                send_bit(1'b0, 1'b0);
                exp_err++;
                live = 1'b0;
                chk("sep_err_locked", bus.locked_o, 0);
                chk("sep_err_errcnt", bus.err_count_o, exp_err);
            end else if (err_kind == 2 && p == err_pos) begin
                send_bit(b, 1'b1);
                exp_err++;
                live = 1'b0;
                chk("sync_err_locked", bus.locked_o, 0);
                chk("sync_err_errcnt", bus.err_count_o, exp_err);
            end else begin
                send_bit(b, 1'b0);
            end
            exp_sv = live && (p >= 34) && (p <= 244) && ((p - 34) % 30 == 0);
            chk($sformatf("sample_valid_p%0d", p), bus.sample_valid_o, exp_sv);
            if (exp_sv) begin
                c = (p - 34) / 30;
                chk($sformatf("channel_p%0d", p), bus.channel_o, c);
                chk($sformatf("sample_ch%0d", c), bus.sample_o, base + 24'(c));
            end
            chk($sformatf("frame_p%0d", p), bus.frame_o, live && (p == 255));
            if (p == 255 && err_kind == 0)
                chk("user_bits", bus.user_o, user);
        end
    endtask

    initial begin
        bus.data_i  = 1'b0;
        bus.valid_i = 1'b0;
        bus.sync_i  = 1'b0;

        // Reset with random input activity.
        rst_i = 1'b1;
        repeat (5) drive(1'($urandom), 1'($urandom), 1'($urandom));
        rst_i = 1'b0;
        chk("rst_sample", bus.sample_o, 0);
        chk("rst_channel", bus.channel_o, 0);
        chk("rst_sample_valid", bus.sample_valid_o, 0);
        chk("rst_user", bus.user_o, 0);
        chk("rst_frame", bus.frame_o, 0);
        chk("rst_locked", bus.locked_o, 0);
        chk("rst_errcnt", bus.err_count_o, 0);

        // Acquisition and lock.
        tb_run = 0;
        repeat (12) send_bit(1'b0, 1'b0);
        send_frame(4'hA, 24'hC0FFE0, 1'b0, 0, 0);
        chk("lock_after_f1", bus.locked_o, 0);
        send_frame(4'hA, 24'hC0FFE0, 1'b0, 0, 0);
        chk("lock_after_f2", bus.locked_o, 1);
        send_frame(4'hA, 24'hC0FFE0, 1'b1, 0, 0);
        chk("lock_after_f3", bus.locked_o, 1);

        // Separator error at p100, then re-lock.
        send_frame(4'h5, 24'h123450, 1'b1, 1, 100);
        send_frame(4'h5, 24'h123450, 1'b0, 0, 0);
        chk("relock1_f1", bus.locked_o, 0);
        send_frame(4'h5, 24'h123450, 1'b0, 0, 0);
        chk("relock1_f2", bus.locked_o, 1);
        send_frame(4'h5, 24'h123450, 1'b1, 0, 0);

        // Spurious sync at p50.
        send_frame(4'h6, 24'hABCDE0, 1'b1, 2, 50);
        send_frame(4'h6, 24'hABCDE0, 1'b0, 0, 0);
        send_frame(4'h6, 24'hABCDE0, 1'b0, 0, 0);
        chk("relock2", bus.locked_o, 1);

        // Decoder dropout at p120.
        send_frame(4'h7, 24'h5A5A50, 1'b1, 3, 120);
        send_frame(4'h7, 24'h5A5A50, 1'b0, 0, 0);
        chk("relock3_f1", bus.locked_o, 0);
        send_frame(4'h7, 24'h5A5A50, 1'b0, 0, 0);
        chk("relock3_f2", bus.locked_o, 1);

        // 11-zero sync: a zero at p0 is an error, and the following 1 restarts deframing.
        send_bit(1'b0, 1'b0);
        exp_err++;
        chk("longsync_locked", bus.locked_o, 0);
        chk("longsync_errcnt", bus.err_count_o, exp_err);
        send_frame(4'h3, 24'h0F0F00, 1'b0, 0, 0);
        chk("longsync_not_locked", bus.locked_o, 0);

        // Error counter saturation.
        gap();
        exp_err++;
        chk("gap_errcnt", bus.err_count_o, exp_err);
        repeat (300) begin
            repeat (10) send_bit(1'b0, 1'b0);
            send_bit(1'b1, 1'b0);
            gap();
        end
        chk("errcnt_saturated", bus.err_count_o, 255);

        // Reset in the middle of a frame clears everything.
        repeat (10) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rst_i = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        rst_i = 1'b0;
        chk("midrst_errcnt", bus.err_count_o, 0);
        chk("midrst_user", bus.user_o, 0);
        chk("midrst_sample", bus.sample_o, 0);
        chk("midrst_locked", bus.locked_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adat_frame_deframer.md
# adat_frame_deframer

Consumes the recovered ADAT bit stream from the NRZI phase-lock decoder and splits each 256-bit ADAT frame into eight 24-bit channel samples plus the 4 user bits. It sits directly downstream of the decoder in the `clk_i` domain. The deframer acquires and checks frame alignment, declares lock after a configurable number of clean frames, and emits one sample strobe per channel. Its outputs feed the sample FIFO and USB packetiser.

## Interface
- `LOCK_FRAMES`, default 2: number of consecutive error-free frames required before `locked_o` asserts; range 1..15.
- `clk_i` in 1: single clock, the decoder's `clk_i`. One bit is offered per cycle.
- `rst_i` in 1: reset, synchronous and active-high.
- `data_i` in 1: decoded bit.
- `valid_i` in 1: decoder synced; `data_i` is meaningful only when this is 1.
- `sync_i` in 1: decoder zero-run flag, high while its zero run is 8..15.
- `sample_o` out 24: channel sample, MSB first as received.
- `channel_o` out 3: channel index of `sample_o`.
- `sample_valid_o` out 1: one-cycle strobe qualifying `sample_o` and `channel_o`.
- `user_o` out 4: user bits of the last completed frame.
- `frame_o` out 1: one-cycle strobe at the end of each good frame while locked.
- `locked_o` out 1: frame lock.
- `err_count_o` out 8: saturating count of framing errors.

## Operation
- **Bit acceptance.** A bit is accepted on any cycle where `valid_i` is 1.
- **Zero-run counter.** 4 bits, saturates at 15.
  - Increments on an accepted 0.
  - Clears on an accepted 1 or when `valid_i` is 0.
  - Runs in every state.
- **Frame position.** `p` is 0..255. p0 is the 1 that ends the sync pattern.
  - p1–p4: user bits, MSB first.
  - p5: separator 1.
  - Nibble k (0..47) occupies p(6+5k)..p(9+5k). Its separator 1 is at p(10+5k).
  - p246–p255: ten sync zeros.
- **States.**
  - HUNT: entered on reset and on any error.
    - An accepted 1 with zero-run ≥ 10 moves to FRAME with p set to 1 for the next bit.
  - FRAME: each accepted bit is checked, then `p` increments.
    - `p` wraps 255→0. p0 must be 1.
- **Errors (FRAME only).**
  - 0 at p0, p5 or any separator.
  - 1 at p246–p255.
  - `sync_i` = 1 on a bit with p < 253.
  - `valid_i` = 0.
- **Error response.**
  - Go to HUNT.
  - Increment `err_count_o` (saturating at 255).
  - Clear the good-frame counter.
  - Drop `locked_o`.
  - Discard any partial sample.
  - The error bit itself still updates the zero-run counter. A 0 at p0 with run ≥ 10 therefore lets HUNT restart on the next 1.
- **Sample assembly.** Each nibble shifts into a 24-bit register. Channel c is complete at the last bit of nibble 6c+5, i.e. p = 34+30c.
- **Sample emission.** On completion, if `locked_o` is 1: load `sample_o` and `channel_o` = c, and pulse `sample_valid_o`.
- **Frame completion.** An accepted p255 with no error:
  - Load `user_o`.
  - Pulse `frame_o` if `locked_o` was already 1.
  - Increment the good-frame counter (saturating at `LOCK_FRAMES`).
  - Set `locked_o` when the counter reaches `LOCK_FRAMES`.

## Timing
- **Registered outputs.** All outputs are registered and update the cycle after the accepted bit that causes them (latency 1).
- **Reset values.** All outputs are 0. State is HUNT and all counters are 0.
- **Strobes.**
  - `sample_valid_o` and `frame_o` are single-cycle.
  - At most one `sample_valid_o` per 30 accepted bits.
  - `sample_o`, `channel_o` and `user_o` hold their values between strobes.
- **Loss of lock.** `locked_o` falls the cycle after an error bit.
- **No sample on error.** A sample completing on the same bit as an error is not emitted.
- **Gaps.** Cycles with `valid_i` = 0 in HUNT are ignored apart from clearing the zero run.
- **Reset priority.** `rst_i` wins over every event. Asserting it mid-frame returns to HUNT with outputs cleared on the next cycle.

## Test plan
- **Reset.** Drive random `data_i` with `rst_i` = 1 for 5 cycles → all outputs 0, `err_count_o` = 0.
- **Acquisition and lock.** Send 12 zeros followed by 3 clean frames: user = 0xA, channel c = 0xC0FFE0+c, `sync_i` modelled as the decoder's.
  - `locked_o` rises 1 cycle after p255 of frame 2.
  - Frame 3 gives 8 strobes, one cycle after p = 34+30c, with channel_o = c and sample_o = 0xC0FFE0+c.
  - `frame_o` pulses once with `user_o` = 0xA.
- **Separator error.** When locked, force the separator at p100 to 0.
  - `locked_o` = 0 and `err_count_o` = 1 on the next cycle.
  - No strobes until 2 further clean frames complete.
- **Spurious sync.** When locked, assert `sync_i` on a bit at p50 → error, HUNT, `err_count_o` +1.
- **Decoder dropout.** Drop `valid_i` for 3 cycles at p120 → one error counted, HUNT.
  - Re-acquire on the next sync, then lock after `LOCK_FRAMES` frames.
- **Long sync and saturation.** Send an 11-zero sync (0 at p0) → error.
  - Deframing restarts at the following 1, and that frame completes as good.
  - Inject 300 errors → `err_count_o` holds at 255.
